// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and parity mode constants for the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
endpackage

// File: rtl/uart_sync_bit.sv
// uart_sync_bit: multi-flop synchroniser for one asynchronous bit, resets to idle-high
module uart_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk)
    if (reset) ff <= '1;
    else ff <= {ff[SYNC_STAGES-2:0], d};
  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_v2.sv
// uart_rx_v2: oversampling UART receiver with majority vote, valid/ready output and error status
module uart_rx_v2
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY      = 0,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 brk,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2((DATA_BITS > STOP_BITS ? DATA_BITS : STOP_BITS) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bidx, bidx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [1:0] hist;
  logic rx_s, vote, last, ferr, ferr_n, pbit, pbit_n, done, fe_done, pe_done, brk_det;
  uart_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .reset(reset), .d(rx), .q(rx_s));
  // vote covers the current sample plus the two previous tick samples
  assign vote    = (hist[0] & hist[1]) | (rx_s & (hist[0] | hist[1]));
  assign last    = cnt == CW'(OVERSAMPLE - 1);
  assign fe_done = ferr | ~vote;
  assign pe_done = PARITY == PARITY_EVEN ? ^shreg ^ pbit :
                   PARITY == PARITY_ODD  ? ~(^shreg ^ pbit) : 1'b0;
  assign brk_det = shreg == '0 && (PARITY == PARITY_NONE || !pbit) && fe_done;
  assign busy    = state != S_IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      bidx  <= '0;
      shreg <= '0;
      ferr  <= 1'b0;
      pbit  <= 1'b0;
      hist  <= 2'b11;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      shreg <= shreg_n;
      ferr  <= ferr_n;
      pbit  <= pbit_n;
      if (tick) hist <= {hist[0], rx_s};
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    shreg_n = shreg;
    ferr_n  = ferr;
    pbit_n  = pbit;
    done    = 1'b0;
    if (tick)
      case (state)
        S_IDLE:
          if (!rx_s) begin
            state_n = S_START;
            cnt_n   = '0;
          end
        S_START:
          if (cnt == CW'(OVERSAMPLE / 2 - 1)) begin
            state_n = vote ? S_IDLE : S_DATA;
            cnt_n   = '0;
            bidx_n  = '0;
            ferr_n  = 1'b0;
          end else cnt_n = cnt + 1'b1;
        S_DATA: begin
          cnt_n = last ? '0 : cnt + 1'b1;
          if (last) begin
            shreg_n = {vote, shreg[DATA_BITS-1:1]};
            bidx_n  = bidx == BW'(DATA_BITS - 1) ? '0 : bidx + 1'b1;
            if (bidx == BW'(DATA_BITS - 1)) state_n = PARITY != PARITY_NONE ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          cnt_n = last ? '0 : cnt + 1'b1;
          if (last) begin
            pbit_n  = vote;
            state_n = S_STOP;
          end
        end
        S_STOP: begin
          cnt_n = last ? '0 : cnt + 1'b1;
          if (last) begin
            ferr_n = fe_done;
            bidx_n = bidx + 1'b1;
            if (bidx == BW'(STOP_BITS - 1)) begin
              done    = 1'b1;
              bidx_n  = '0;
              state_n = brk_det ? S_BRK_WAIT : S_IDLE;
            end
          end
        end
        S_BRK_WAIT: if (rx_s) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      brk        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      brk     <= done & brk_det;
      if (done && (!m_valid || m_ready)) begin
        m_data     <= shreg;
        parity_err <= pe_done;
        frame_err  <= fe_done;
        m_valid    <= 1'b1;
      end else if (done) overrun <= 1'b1;
      else if (m_ready) m_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_v2.sv
// tb_uart_rx_v2: directed scoreboard bench for an 8N1 receiver and an odd-parity receiver
module tb_uart_rx_v2;
  typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, m_ready0 = 1'b1, m_ready1 = 1'b1;
  logic [7:0] md0, md1;
  logic mv0, pe0, fe0, ov0, bk0, busy0, mv1, pe1, fe1, ov1, bk1, busy1;
  int tests = 0, fails = 0, cyc = 0;
  int mv0_n = 0, ovr0_n = 0, brk0_n = 0;
  exp_t q0[$], q1[$];

  uart_rx_v2 dut0 (.clk(clk), .reset(reset), .tick(tick), .rx(rx0), .m_data(md0), .m_valid(mv0),
    .m_ready(m_ready0), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .brk(bk0), .busy(busy0));
  uart_rx_v2 #(.PARITY(2)) dut1 (.clk(clk), .reset(reset), .tick(tick), .rx(rx1), .m_data(md1),
    .m_valid(mv1), .m_ready(m_ready1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .brk(bk1),
    .busy(busy1));

  initial forever #5 clk = ~clk;

  always @(negedge clk) if (!reset) begin
    exp_t e;
    if (ov0) ovr0_n++;
    if (bk0) brk0_n++;
    if (mv0) mv0_n++;
    if (mv0 && m_ready0) begin
      tests++;
      assert ((q0.size() != 0) === 1'b1) else begin fails++; $error("FAIL pop0 unexpected word observed=%h expected=none", md0); end
      if (q0.size() != 0) begin
        e = q0.pop_front();
        tests++;
        assert (md0 === e.d) else begin fails++; $error("FAIL data0 observed=%h expected=%h", md0, e.d); end
        tests++;
        assert ({pe0, fe0} === {e.pe, e.fe}) else begin fails++; $error("FAIL flags0 observed=%b expected=%b", {pe0, fe0}, {e.pe, e.fe}); end
      end
    end
  end

  always @(negedge clk) if (!reset && mv1 && m_ready1) begin
    exp_t e;
    tests++;
    assert ((q1.size() != 0) === 1'b1) else begin fails++; $error("FAIL pop1 unexpected word observed=%h expected=none", md1); end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      tests++;
      assert (md1 === e.d) else begin fails++; $error("FAIL data1 observed=%h expected=%h", md1, e.d); end
      tests++;
      assert ({pe1, fe1} === {e.pe, e.fe}) else begin fails++; $error("FAIL flags1 observed=%b expected=%b", {pe1, fe1}, {e.pe, e.fe}); end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin fails++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick = (cyc % 4 == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [15:0] frm(input logic [7:0] d);
    return {7'h7F, d, 1'b0};
  endfunction

  function automatic logic [15:0] frmp(input logic [7:0] d, input logic p);
    return {6'h3F, p, d, 1'b0};
  endfunction

  // one bit = 16 ticks = 64 clocks; frames always start at the same tick phase
  task automatic send(input int sel, input logic [15:0] pat, input int nbits, input int rdy_at,
                      input int spike_at, input int abort_at, output int first_v);
    logic b;
    first_v = -1;
    while (cyc % 4 != 0) step();
    for (int c = 0; c < nbits * 64; c++) begin
      if (c == abort_at) return;
      b = pat[c/64];
      if (spike_at >= 0 && c >= spike_at && c < spike_at + 4) b = 1'b0;
      if (sel == 0) rx0 = b; else rx1 = b;
      step();
      if (c == rdy_at) m_ready0 = 1'b1;
      if (rdy_at >= 0 && c == rdy_at + 1) m_ready0 = 1'b0;
      if (first_v < 0 && (sel == 0 ? mv0 : mv1)) first_v = c;
    end
    rx0 = 1'b1;
    rx1 = 1'b1;
  endtask

  initial begin
    int n, fv, v, o, b;
    logic seen;
    idle(5);
    reset = 1'b0;
    step();
    chk("reset_out0", 32'({mv0, md0, pe0, fe0, ov0, bk0, busy0}), 0);
    chk("reset_out1", 32'({mv1, md1, pe1, fe1, ov1, bk1, busy1}), 0);

    v = mv0_n;
    q0.push_back('{8'hA5, 1'b0, 1'b0});
    send(0, frm(8'hA5), 10, -1, -1, -1, fv);
    idle(100);
    chk("a5_valid_cycles", mv0_n - v, 1);
    chk("a5_drained", q0.size(), 0);

    q1.push_back('{8'h3C, 1'b1, 1'b0});
    send(1, frmp(8'h3C, 1'b0), 11, -1, -1, -1, fv);
    idle(100);
    q1.push_back('{8'h3C, 1'b0, 1'b0});
    send(1, frmp(8'h3C, 1'b1), 11, -1, -1, -1, fv);
    idle(100);
    chk("parity_drained", q1.size(), 0);

    v = mv0_n;
    seen = 1'b0;
    rx0 = 1'b0;
    repeat (16) begin step(); seen |= busy0; end
    rx0 = 1'b1;
    idle(80);
    chk("glitch_busy_seen", 32'(seen), 1);
    chk("glitch_busy_end", 32'(busy0), 0);
    chk("glitch_no_valid", mv0_n - v, 0);

    m_ready0 = 1'b0;
    q0.push_back('{8'h11, 1'b0, 1'b0});
    send(0, frm(8'h11), 10, -1, -1, -1, n);
    idle(60);
    chk("ovr_hold_valid", 32'(mv0), 1);
    o = ovr0_n;
    send(0, frm(8'h22), 10, -1, -1, -1, fv);
    idle(60);
    chk("ovr_pulse", ovr0_n - o, 1);
    chk("ovr_held_data", 32'(md0), 32'h11);
    q0.push_back('{8'h33, 1'b0, 1'b0});
    o = ovr0_n;
    send(0, frm(8'h33), 10, n - 1, -1, -1, fv);
    chk("same_cycle_valid", 32'(mv0), 1);
    chk("same_cycle_data", 32'(md0), 32'h33);
    chk("same_cycle_no_ovr", ovr0_n - o, 0);
    m_ready0 = 1'b1;
    idle(20);
    chk("ovr_drained", q0.size(), 0);

    b = brk0_n;
    q0.push_back('{8'h00, 1'b0, 1'b1});
    while (cyc % 4 != 0) step();
    rx0 = 1'b0;
    idle(1280);
    rx0 = 1'b1;
    idle(800);
    chk("brk_pulse", brk0_n - b, 1);
    chk("brk_drained", q0.size(), 0);
    chk("brk_busy_end", 32'(busy0), 0);

    q0.push_back('{8'hFF, 1'b0, 1'b0});
    send(0, frm(8'hFF), 10, -1, 288, -1, fv);
    idle(100);
    chk("spike_drained", q0.size(), 0);

    m_ready0 = 1'b0;
    send(0, frm(8'h77), 10, -1, -1, -1, fv);
    idle(60);
    chk("rst_pre_valid", 32'(mv0), 1);
    send(0, frm(8'h55), 10, -1, -1, 200, fv);
    chk("rst_pre_busy", 32'(busy0), 1);
    rx0 = 1'b1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    step();
    chk("rst_mid_valid", 32'(mv0), 0);
    chk("rst_mid_busy", 32'(busy0), 0);
    m_ready0 = 1'b1;
    idle(40);
    q0.push_back('{8'h5A, 1'b0, 1'b0});
    send(0, frm(8'h5A), 10, -1, -1, -1, fv);
    idle(100);
    chk("post_reset_drained", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
